encoder_value_ctrl: RTL and testbench

//  Downstream consumer of the rotary Encoder block. Turns its one-cycle Increment/Decrement

---
 rtl/encoder_value_ctrl_pkg.sv | 9 +
 rtl/encoder_value_ctrl_ms_tick.sv | 20 ++
 rtl/encoder_value_ctrl.sv | 126 ++++++++++++
 tb/tb_encoder_value_ctrl.sv | 134 +++++++++++++
 4 files changed

// File: rtl/encoder_value_ctrl_pkg.sv
// encoder_value_ctrl_pkg: shared state encodings, direction codes and ms-tick divisor helper
package encoder_value_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, HELD, HELD_ROT, LONG} btn_state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN} dir_t;
  localparam int unsigned MS_PER_S = 1000;
  function automatic int unsigned ms_div(input int unsigned hz);
    return (hz / MS_PER_S < 1) ? 1 : hz / MS_PER_S;
  endfunction
endpackage

// File: rtl/encoder_value_ctrl_ms_tick.sv
// encoder_value_ctrl_ms_tick: free-running prescaler producing a one-cycle tick every DIV clocks
module encoder_value_ctrl_ms_tick #(
  parameter int unsigned DIV = 10000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  logic [CW-1:0] cnt;
  // count 0..DIV-1 and pulse on wrap
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= cnt == CW'(DIV - 1);
      cnt  <= cnt == CW'(DIV - 1) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/encoder_value_ctrl.sv
// encoder_value_ctrl: bounded value register driven by encoder detents and button events
module encoder_value_ctrl
  import encoder_value_ctrl_pkg::*;
#(
  parameter int unsigned CLOCK_HZ        = 10_000_000,
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned MIN_VALUE       = 0,
  parameter int unsigned MAX_VALUE       = 100,
  parameter int unsigned DEFAULT_VALUE   = 50,
  parameter int unsigned FINE_STEP       = 1,
  parameter int unsigned COARSE_STEP     = 10,
  parameter bit          WRAP            = 1'b0,
  parameter int unsigned ACCEL_WINDOW_MS = 50,
  parameter int unsigned ACCEL_FACTOR    = 4,
  parameter int unsigned LONG_PRESS_MS   = 500
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             increment,
  input  logic             decrement,
  input  logic             button_press,
  input  logic             button_release,
  output logic [WIDTH-1:0] value,
  output logic             coarse,
  output logic             changed,
  output logic             long_press
);
  localparam int E  = WIDTH + 2;
  localparam int AW = $clog2(ACCEL_WINDOW_MS + 1);
  localparam int HW = $clog2(LONG_PRESS_MS + 1);

  logic             tick;
  btn_state_t       state, state_nx;
  dir_t             last_dir, dir;
  logic [AW-1:0]    since_ms;
  logic [HW-1:0]    hold_ms;
  logic             detent, press_evt, rel_evt, hold_done, toggle, restore, apply, accel;
  logic [E-1:0]     base, step, cur, up, dn, next_up, next_dn, target;
  logic [WIDTH-1:0] new_val;

  encoder_value_ctrl_ms_tick #(.DIV(ms_div(CLOCK_HZ))) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  assign detent    = increment ^ decrement;
  assign dir       = increment ? DIR_UP : DIR_DOWN;
  assign press_evt = button_press & ~button_release;
  assign rel_evt   = button_release & ~button_press;
  assign hold_done = tick && hold_ms == HW'(LONG_PRESS_MS - 1) && (state == HELD || state == HELD_ROT);

  // button state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;

  // button next state; release beats a simultaneous long-press expiry
  always_comb begin
    state_nx = state;
    toggle   = 1'b0;
    restore  = 1'b0;
    unique case (state)
      IDLE: if (press_evt) state_nx = HELD;
      HELD:
        if (rel_evt) begin
          state_nx = IDLE;
          toggle   = 1'b1;
        end else if (hold_done) begin
          state_nx = LONG;
          restore  = 1'b1;
        end else if (detent) state_nx = HELD_ROT;
      HELD_ROT:
        if (rel_evt) state_nx = IDLE;
        else if (hold_done) begin
          state_nx = LONG;
          restore  = 1'b1;
        end
      LONG: if (rel_evt) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // hold time in ms, cleared whenever the button is up, saturating at the long-press limit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) hold_ms <= '0;
    else if (state == IDLE) hold_ms <= '0;
    else if (tick && hold_ms != HW'(LONG_PRESS_MS)) hold_ms <= hold_ms + 1'b1;

  assign apply = detent && !restore;
  assign accel = dir == last_dir && since_ms < AW'(ACCEL_WINDOW_MS);

  // remember direction of the last applied detent and ms elapsed since it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      last_dir <= DIR_NONE;
      since_ms <= '0;
    end else if (apply) begin
      last_dir <= dir;
      since_ms <= '0;
    end else if (tick && since_ms != AW'(ACCEL_WINDOW_MS)) since_ms <= since_ms + 1'b1;

  assign base    = coarse ? E'(COARSE_STEP) : E'(FINE_STEP);
  assign step    = accel ? E'(base * ACCEL_FACTOR) : base;
  assign cur     = E'(value);
  assign up      = cur + step;
  assign dn      = cur - step;
  assign next_up = up > E'(MAX_VALUE) ? (WRAP ? E'(MIN_VALUE) : E'(MAX_VALUE)) : up;
  assign next_dn = cur >= E'(MIN_VALUE) + step ? dn : (WRAP ? E'(MAX_VALUE) : E'(MIN_VALUE));
  assign target  = restore ? E'(DEFAULT_VALUE) : apply ? (dir == DIR_UP ? next_up : next_dn) : cur;
  assign new_val = WIDTH'(target);

  // output registers; changed only when the stored value really moves
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      value      <= WIDTH'(DEFAULT_VALUE);
      coarse     <= 1'b0;
      changed    <= 1'b0;
      long_press <= 1'b0;
    end else begin
      value      <= new_val;
      coarse     <= coarse ^ toggle;
      changed    <= new_val != value;
      long_press <= restore;
    end
endmodule

// File: tb/tb_encoder_value_ctrl.sv
// tb_encoder_value_ctrl: directed self-checking bench, 10 clocks per ms
module tb_encoder_value_ctrl;
  localparam logic [3:0] INC = 4'b1000, DEC = 4'b0100, PRS = 4'b0010, REL = 4'b0001;
  localparam int CPM = 10;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic [3:0] ev = 4'b0;
  logic [7:0] value, value_w;
  logic       coarse, changed, long_press, coarse_w, changed_w, long_press_w;
  int n_assert = 0, n_fail = 0;
  int exp_s[7] = '{43, 33, 23, 13, 3, 0, 0};
  int lp_cnt, lp_at, lp_val, lp_chg;

  always #5 clk = ~clk;

  encoder_value_ctrl #(.CLOCK_HZ(10_000)) dut (
    .clk(clk), .rst_n(rst_n), .increment(ev[3]), .decrement(ev[2]),
    .button_press(ev[1]), .button_release(ev[0]),
    .value(value), .coarse(coarse), .changed(changed), .long_press(long_press)
  );

  encoder_value_ctrl #(.CLOCK_HZ(10_000), .WRAP(1'b1)) dut_w (
    .clk(clk), .rst_n(rst_n), .increment(ev[3]), .decrement(ev[2]),
    .button_press(ev[1]), .button_release(ev[0]),
    .value(value_w), .coarse(coarse_w), .changed(changed_w), .long_press(long_press_w)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [3:0] e);
    @(posedge clk); #1 ev = e;
    @(posedge clk); #1 ev = 4'b0;
  endtask

  task automatic wait_ms(input int n);
    repeat (n * CPM) @(posedge clk);
  endtask

  task automatic watch_long(input int cycles);
    lp_cnt = 0; lp_at = -1; lp_val = 0; lp_chg = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (long_press) begin
        lp_cnt++;
        if (lp_at < 0) begin
          lp_at = i; lp_val = value; lp_chg = changed;
        end
      end
    end
  endtask

  initial begin
    #25 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_value", value, 50);
    chk("reset_coarse", coarse, 0);
    chk("reset_changed", changed, 0);
    chk("reset_long", long_press, 0);
    chk("reset_value_wrap", value_w, 50);
    for (int i = 0; i < 3; i++) begin
      wait_ms(100);
      pulse(INC);
      chk("inc_value", value, 51 + i);
      chk("inc_changed", changed, 1);
    end
    @(posedge clk); #1;
    chk("changed_one_cycle", changed, 0);
    pulse(PRS);
    wait_ms(1);
    pulse(REL);
    chk("short_press_coarse", coarse, 1);
    for (int i = 0; i < 7; i++) begin
      wait_ms(100);
      pulse(DEC);
      chk("coarse_dec_value", value, exp_s[i]);
      chk("coarse_dec_changed", changed, i < 6);
      if (i == 5) chk("wrap_below_min", value_w, 100);
      if (i == 6) chk("wrap_after_wrap", value_w, 90);
    end
    pulse(PRS);
    wait_ms(1);
    pulse(REL);
    chk("back_to_fine", coarse, 0);
    wait_ms(100);
    pulse(INC);
    chk("fine_inc", value, 1);
    wait_ms(10);
    pulse(INC);
    chk("accel_inc", value, 5);
    wait_ms(10);
    pulse(DEC);
    chk("dir_change_dec", value, 4);
    wait_ms(100);
    pulse(PRS);
    watch_long(600 * CPM);
    pulse(REL);
    chk("long_seen_once", lp_cnt, 1);
    chk("long_timing", lp_at >= 4980 && lp_at <= 5010, 1);
    chk("long_value", lp_val, 50);
    chk("long_changed", lp_chg, 1);
    chk("long_keeps_coarse", coarse, 0);
    chk("after_long_value", value, 50);
    wait_ms(100);
    pulse(PRS);
    wait_ms(100);
    pulse(INC);
    chk("held_rot_value", value, 51);
    wait_ms(100);
    pulse(REL);
    chk("held_rot_no_toggle", coarse, 0);
    chk("held_rot_keep", value, 51);
    wait_ms(100);
    pulse(INC | DEC);
    chk("inc_dec_value", value, 51);
    chk("inc_dec_changed", changed, 0);
    pulse(PRS);
    wait_ms(300);
    #1 rst_n = 1'b0;
    #20 rst_n = 1'b1;
    chk("midhold_reset_value", value, 50);
    watch_long(600 * CPM);
    pulse(REL);
    chk("midhold_no_long", lp_cnt, 0);
    chk("midhold_coarse", coarse, 0);
    chk("midhold_value", value, 50);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
